// File: rtl/ctrlport_status_forwarder.sv
// Forwards debounced status bits to a remote ControlPort register as single writes,
// with ack timeout, bounded retry, sticky fault and optional periodic refresh.
module ctrlport_status_forwarder #(
  parameter int          NUM_BITS        = 2,
  parameter logic [19:0] DEST_ADDR       = 20'h0,
  parameter int          BIT_OFFSET      = 0,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          TIMEOUT_CYCLES  = 1024,
  parameter int          MAX_RETRIES     = 3,
  parameter int          REFRESH_CYCLES  = 0
) (
  input  logic                ctrlport_clk,
  input  logic                ctrlport_rst_n,
  output logic                m_ctrlport_req_wr,
  output logic                m_ctrlport_req_rd,
  output logic [19:0]         m_ctrlport_req_addr,
  output logic [31:0]         m_ctrlport_req_data,
  output logic [3:0]          m_ctrlport_req_byte_en,
  input  logic                m_ctrlport_resp_ack,
  input  logic [1:0]          m_ctrlport_resp_status,
  input  logic [31:0]         m_ctrlport_resp_data,
  input  logic                enable,
  input  logic [NUM_BITS-1:0] status_in,
  output logic                busy,
  output logic                fault,
  output logic [NUM_BITS-1:0] stable_status
);

  localparam logic [1:0] CTRL_STS_OKAY = 2'd0;

  localparam int DB_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RT_W  = $clog2(MAX_RETRIES + 1);
  localparam int RF_W  = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RF_W-1:0]  RF_LAST  = RF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FAULT
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_BITS-1:0] sent_value_reg, sent_value_next;
  logic                req_wr_reg, req_wr_next;
  logic                fault_reg, fault_next;
  logic                retry_pending_reg, retry_pending_next;
  logic [RT_W-1:0]     retry_cnt_reg, retry_cnt_next;
  logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
  logic [RF_W-1:0]     refresh_cnt_reg, refresh_cnt_next;
  logic                enable_d_reg;

  logic [NUM_BITS-1:0] status_pol;
  logic [NUM_BITS-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_BITS-1:0] synced;
  logic                enable_rise, enable_fall, refresh_hit, timeout_hit, trigger;
  logic [RT_W-1:0]     retry_inc;
  logic                unused_resp_data;

  assign unused_resp_data = ^m_ctrlport_resp_data;

  // Polarity correction happens before synchronisation so everything downstream is active-high.
  assign status_pol = ACTIVE_LOW ? ~status_in : status_in;
  assign synced     = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= status_pol;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_debounce
    logic bit_reg;
    if (DEBOUNCE_CYCLES == 0) begin : g_pass
      always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) bit_reg <= 1'b0;
        else                 bit_reg <= synced[gi];
      end
    end else begin : g_count
      logic [DB_W-1:0] cnt_reg;
      // Counter restarts whenever the synced bit agrees with the accepted value.
      always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
          bit_reg <= 1'b0;
          cnt_reg <= '0;
        end else if (synced[gi] == bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          bit_reg <= synced[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
    assign stable_status[gi] = bit_reg;
  end

  assign enable_rise = enable & ~enable_d_reg;
  assign enable_fall = ~enable & enable_d_reg;
  assign refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt_reg == RF_LAST);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt_reg == TMO_LAST);
  assign trigger     = (stable_status != sent_value_reg) || enable_rise ||
                       retry_pending_reg || refresh_hit;
  assign retry_inc   = retry_cnt_reg + 1'b1;

  always_comb begin
    state_next         = state_reg;
    sent_value_next    = sent_value_reg;
    req_wr_next        = 1'b0;
    fault_next         = fault_reg;
    retry_pending_next = retry_pending_reg;
    retry_cnt_next     = retry_cnt_reg;
    tmo_cnt_next       = tmo_cnt_reg;
    refresh_cnt_next   = refresh_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable && trigger) begin
          state_next       = ST_WAIT;
          req_wr_next      = 1'b1;
          sent_value_next  = stable_status;
          tmo_cnt_next     = '0;
          refresh_cnt_next = '0;
        end else if (enable && (REFRESH_CYCLES > 0) && !refresh_hit) begin
          refresh_cnt_next = refresh_cnt_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        // An ack in the same cycle as the timeout takes precedence.
        if (m_ctrlport_resp_ack && (m_ctrlport_resp_status == CTRL_STS_OKAY)) begin
          state_next         = ST_IDLE;
          retry_cnt_next     = '0;
          retry_pending_next = 1'b0;
        end else if (m_ctrlport_resp_ack || timeout_hit) begin
          retry_cnt_next = retry_inc;
          if (retry_inc == RT_MAX) begin
            state_next         = ST_FAULT;
            fault_next         = 1'b1;
            retry_pending_next = 1'b0;
          end else begin
            state_next         = ST_IDLE;
            retry_pending_next = 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      ST_FAULT: begin
        if (enable_fall) begin
          state_next         = ST_IDLE;
          fault_next         = 1'b0;
          retry_cnt_next     = '0;
          retry_pending_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      state_reg         <= ST_IDLE;
      sent_value_reg    <= '0;
      req_wr_reg        <= 1'b0;
      fault_reg         <= 1'b0;
      retry_pending_reg <= 1'b0;
      retry_cnt_reg     <= '0;
      tmo_cnt_reg       <= '0;
      refresh_cnt_reg   <= '0;
      enable_d_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      sent_value_reg    <= sent_value_next;
      req_wr_reg        <= req_wr_next;
      fault_reg         <= fault_next;
      retry_pending_reg <= retry_pending_next;
      retry_cnt_reg     <= retry_cnt_next;
      tmo_cnt_reg       <= tmo_cnt_next;
      refresh_cnt_reg   <= refresh_cnt_next;
      enable_d_reg      <= enable;
    end
  end

  assign m_ctrlport_req_wr      = req_wr_reg;
  assign m_ctrlport_req_rd      = 1'b0;
  assign m_ctrlport_req_addr    = DEST_ADDR;
  assign m_ctrlport_req_data    = 32'(sent_value_reg) << BIT_OFFSET;
  assign m_ctrlport_req_byte_en = 4'hF;
  assign busy                   = (state_reg == ST_WAIT);
  assign fault                  = fault_reg;

endmodule

// File: tb/tb_ctrlport_status_forwarder.sv
// Directed bench for ctrlport_status_forwarder: debounce vector table plus
// retry, timeout/fault, fault recovery, reset-abandon and refresh sequences.
module tb_ctrlport_status_forwarder;

  localparam int ACK_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n, r_rst_n;
  logic        req_wr, req_rd, r_req_wr, r_req_rd;
  logic [19:0] req_addr, r_req_addr;
  logic [31:0] req_data, r_req_data;
  logic [3:0]  req_be, r_req_be;
  logic        ack, r_ack;
  logic [1:0]  resp_sts, r_resp_sts;
  logic        enable, r_enable;
  logic [1:0]  status_in, r_status_in;
  logic        busy, fault, r_busy, r_fault;
  logic [1:0]  stable, r_stable;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          lat_cnt = 0, r_lat_cnt = 0;
  bit          ack_on = 1'b1;
  int          resp_errs = 0;
  int          wr_count = 0, r_wr_count = 0;
  int          wr_run = 0, wr_run_max = 0;
  logic [31:0] last_data = '0, r_last_data = '0;
  logic [19:0] last_addr = '0;
  int          wr_stamps[$];
  int          r_stamps[$];

  ctrlport_status_forwarder #(
    .NUM_BITS(2), .DEST_ADDR(20'h0ABC), .BIT_OFFSET(0), .ACTIVE_LOW(1'b1),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(1024),
    .MAX_RETRIES(3), .REFRESH_CYCLES(0)
  ) dut (
    .ctrlport_clk(clk), .ctrlport_rst_n(rst_n),
    .m_ctrlport_req_wr(req_wr), .m_ctrlport_req_rd(req_rd),
    .m_ctrlport_req_addr(req_addr), .m_ctrlport_req_data(req_data),
    .m_ctrlport_req_byte_en(req_be), .m_ctrlport_resp_ack(ack),
    .m_ctrlport_resp_status(resp_sts), .m_ctrlport_resp_data(32'h0),
    .enable(enable), .status_in(status_in), .busy(busy), .fault(fault),
    .stable_status(stable)
  );

  ctrlport_status_forwarder #(
    .NUM_BITS(2), .DEST_ADDR(20'h00123), .BIT_OFFSET(0), .ACTIVE_LOW(1'b1),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(1024),
    .MAX_RETRIES(3), .REFRESH_CYCLES(100)
  ) dut_r (
    .ctrlport_clk(clk), .ctrlport_rst_n(r_rst_n),
    .m_ctrlport_req_wr(r_req_wr), .m_ctrlport_req_rd(r_req_rd),
    .m_ctrlport_req_addr(r_req_addr), .m_ctrlport_req_data(r_req_data),
    .m_ctrlport_req_byte_en(r_req_be), .m_ctrlport_resp_ack(r_ack),
    .m_ctrlport_resp_status(r_resp_sts), .m_ctrlport_resp_data(32'h0),
    .enable(r_enable), .status_in(r_status_in), .busy(r_busy), .fault(r_fault),
    .stable_status(r_stable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Responder and write monitor for the main instance, operating on the falling edge.
  always @(negedge clk) begin
    ack      = 1'b0;
    resp_sts = 2'd0;
    if (lat_cnt != 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        ack = 1'b1;
        if (resp_errs > 0) begin
          resp_sts = 2'd2;
          resp_errs--;
        end
      end
    end else if (req_wr && ack_on) begin
      lat_cnt = ACK_LAT;
    end
    if (req_wr) begin
      wr_count++;
      last_data = req_data;
      last_addr = req_addr;
      wr_stamps.push_back(cyc);
      wr_run++;
      if (wr_run > wr_run_max) wr_run_max = wr_run;
    end else begin
      wr_run = 0;
    end
  end

  always @(negedge clk) begin
    r_ack      = 1'b0;
    r_resp_sts = 2'd0;
    if (r_lat_cnt != 0) begin
      r_lat_cnt--;
      if (r_lat_cnt == 0) r_ack = 1'b1;
    end else if (r_req_wr) begin
      r_lat_cnt = ACK_LAT;
    end
    if (r_req_wr) begin
      r_wr_count++;
      r_last_data = r_req_data;
      r_stamps.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  typedef struct {
    logic [1:0]  st_a;
    int          cyc_a;
    logic [1:0]  st_b;
    int          cyc_b;
    int          exp_wr;
    logic [31:0] exp_data;
    logic [1:0]  exp_stable;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, gap, w;

    // status_in is active-low: 2'b11 means both bits inactive.
    vecs[0] = '{2'b10, 10, 2'b11, 40, 0, 32'h0, 2'b00};
    vecs[1] = '{2'b10, 40, 2'b10, 10, 1, 32'h1, 2'b01};
    vecs[2] = '{2'b00, 40, 2'b00, 10, 1, 32'h3, 2'b11};
    vecs[3] = '{2'b01,  5, 2'b00, 40, 0, 32'h3, 2'b11};
    vecs[4] = '{2'b11, 40, 2'b11, 10, 1, 32'h0, 2'b00};
    vecs[5] = '{2'b10, 15, 2'b11, 40, 0, 32'h0, 2'b00};
    vecs[6] = '{2'b10, 16, 2'b10, 30, 1, 32'h1, 2'b01};

    rst_n = 1'b0; r_rst_n = 1'b0;
    enable = 1'b0; r_enable = 1'b0;
    status_in = 2'b11; r_status_in = 2'b11;
    tick(3);
    check("rst_wr", {31'b0, req_wr}, 32'h0);
    check("rst_rd", {31'b0, req_rd}, 32'h0);
    check("rst_addr", {12'b0, req_addr}, 32'h0ABC);
    check("rst_be", {28'b0, req_be}, 32'hF);
    check("rst_data", req_data, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_stable", {30'b0, stable}, 32'h0);

    rst_n = 1'b1;
    tick(3);
    check("idle_no_wr", wr_count, 0);
    enable = 1'b1;
    tick(30);
    check("en_rise_wr", wr_count, 1);
    check("en_rise_data", last_data, 32'h0);
    check("en_rise_addr", {12'b0, last_addr}, 32'h0ABC);
    check("en_rise_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      base = wr_count;
      status_in = vecs[i].st_a;
      tick(vecs[i].cyc_a);
      status_in = vecs[i].st_b;
      tick(vecs[i].cyc_b);
      tick(30);
      check($sformatf("vec%0d_wr", i), wr_count - base, vecs[i].exp_wr);
      check($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
      check($sformatf("vec%0d_stable", i), {30'b0, stable}, {30'b0, vecs[i].exp_stable});
      check($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'h0);
    end

    // Two error responses then success: three strobes, no fault.
    base = wr_count;
    resp_errs = 2;
    status_in = 2'b11;
    tick(80);
    check("slverr_wr", wr_count - base, 3);
    check("slverr_data", last_data, 32'h0);
    check("slverr_fault", {31'b0, fault}, 32'h0);
    check("slverr_busy", {31'b0, busy}, 32'h0);
    check("slverr_used", resp_errs, 0);

    // No ack at all: three timed-out attempts, then sticky fault.
    ack_on = 1'b0;
    base = wr_count;
    status_in = 2'b10;
    tick(25);
    tick(3 * 1025 + 60);
    check("tmo_wr", wr_count - base, 3);
    check("tmo_data", last_data, 32'h1);
    check("tmo_fault", {31'b0, fault}, 32'h1);
    check("tmo_busy", {31'b0, busy}, 32'h0);
    if (wr_stamps.size() >= 3) begin
      for (int k = 1; k <= 2; k++) begin
        gap = wr_stamps[wr_stamps.size()-k] - wr_stamps[wr_stamps.size()-k-1];
        check($sformatf("tmo_gap%0d_min", k), {31'b0, gap >= 1024}, 32'h1);
        check($sformatf("tmo_gap%0d_max", k), {31'b0, gap <= 1100}, 32'h1);
      end
    end
    tick(1500);
    check("fault_no_more_wr", wr_count - base, 3);

    // Status change while faulted is held off; enable toggle clears fault and resends.
    ack_on = 1'b1;
    status_in = 2'b00;
    tick(40);
    check("fault_hold_wr", wr_count - base, 3);
    check("fault_hold_stable", {30'b0, stable}, 32'h3);
    enable = 1'b0;
    tick(4);
    check("fault_clear", {31'b0, fault}, 32'h0);
    check("fault_clear_nowr", wr_count - base, 3);
    base = wr_count;
    enable = 1'b1;
    tick(20);
    check("reenable_wr", wr_count - base, 1);
    check("reenable_data", last_data, 32'h3);
    check("reenable_fault", {31'b0, fault}, 32'h0);

    // Reset while a write is outstanding abandons it.
    ack_on = 1'b0;
    status_in = 2'b11;
    w = 0;
    while (!busy && w < 100) begin
      tick(1);
      w++;
    end
    check("mid_wait_busy", {31'b0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #2;
    check("rst_wait_busy", {31'b0, busy}, 32'h0);
    check("rst_wait_wr", {31'b0, req_wr}, 32'h0);
    check("rst_wait_data", req_data, 32'h0);
    check("rst_wait_stable", {30'b0, stable}, 32'h0);
    tick(3);
    ack_on = 1'b1;
    base = wr_count;
    rst_n = 1'b1;
    tick(20);
    check("post_rst_wr", wr_count - base, 1);
    check("post_rst_busy", {31'b0, busy}, 32'h0);
    check("wr_one_cycle", wr_run_max, 1);

    // Periodic refresh with static inputs.
    r_rst_n = 1'b1;
    tick(3);
    r_enable = 1'b1;
    tick(600);
    check("rf_count", {31'b0, r_stamps.size() >= 4}, 32'h1);
    for (int k = 1; k < r_stamps.size(); k++)
      check($sformatf("rf_gap%0d", k), r_stamps[k] - r_stamps[k-1], 104);
    check("rf_data", r_last_data, 32'h0);
    check("rf_fault", {31'b0, r_fault}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
